// File: rtl/camasir_sepeti_pkg.sv
// Shared types and constants for the camasir_sepeti laundry-basket front end.
// Holds the FSM state encoding and the garment/load widths.
package camasir_sepeti_pkg;

  typedef enum logic [1:0] {
    TOPLA  = 2'd0,
    BASLAT = 2'd1,
    BEKLE  = 2'd2
  } durum_t;

  localparam int NIBBLE_W     = 4;
  localparam int YUK_W        = 16;
  localparam int PARCA_SAYISI = YUK_W / NIBBLE_W;
  localparam int SAYI_W       = $clog2(PARCA_SAYISI + 1);

  localparam logic [NIBBLE_W-1:0] PARCA_BOS = 4'h0;

endpackage

// File: rtl/camasir_sepeti_if.sv
// Garment/load handshake bundle between the upstream source, the basket
// and the downstream wash pipeline.
interface camasir_sepeti_if #(
  parameter int SAYAC_W = 8
);

  logic                                     parca_gecerli;
  logic [camasir_sepeti_pkg::NIBBLE_W-1:0]  parca;
  logic                                     hemen;
  logic                                     bitti;
  logic [camasir_sepeti_pkg::YUK_W-1:0]     camasir;
  logic                                     basla;
  logic                                     hazir;
  logic [SAYAC_W-1:0]                       yuk_sayisi;
  logic                                     hata;

  modport master (
    output parca_gecerli, parca, hemen, bitti,
    input  camasir, basla, hazir, yuk_sayisi, hata
  );

  modport slave (
    input  parca_gecerli, parca, hemen, bitti,
    output camasir, basla, hazir, yuk_sayisi, hata
  );

endinterface

// File: rtl/camasir_sepeti_sepet_paketleyici.sv
// Nibble packer: the k-th accepted garment lands in nibble k of the load,
// alongside the running garment count.
module sepet_paketleyici
  import camasir_sepeti_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_kabul,
  input  logic                i_temizle,
  input  logic [NIBBLE_W-1:0] i_parca,
  output logic [YUK_W-1:0]    o_camasir,
  output logic [SAYI_W-1:0]   o_sayi
);

  logic [SAYI_W-1:0] r_sayi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sayi <= '0;
    end else if (i_temizle) begin
      r_sayi <= '0;
    end else if (i_kabul && (r_sayi != SAYI_W'(PARCA_SAYISI))) begin
      r_sayi <= r_sayi + SAYI_W'(1);
    end
  end

  assign o_sayi = r_sayi;

  // Each nibble owns its own register so the write select is a plain compare.
  for (genvar gi = 0; gi < PARCA_SAYISI; gi++) begin : g_nibble
    logic [NIBBLE_W-1:0] r_nibble;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_nibble <= '0;
      end else if (i_temizle) begin
        r_nibble <= '0;
      end else if (i_kabul && (r_sayi == SAYI_W'(gi))) begin
        r_nibble <= i_parca;
      end
    end

    assign o_camasir[gi*NIBBLE_W +: NIBBLE_W] = r_nibble;
  end

endmodule

// File: rtl/camasir_sepeti.sv
// Laundry-pipeline initiator: collects garments into a load, pulses basla and
// waits for bitti. Optional watchdog on the wait enabled by ZAMAN_ASIMI_EN.
module camasir_sepeti
  import camasir_sepeti_pkg::*;
#(
  parameter int ESIK        = 4,
  parameter int SAYAC_W     = 8,
  parameter int BEKLEME_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  camasir_sepeti_if.slave   bus
);

  localparam logic [SAYI_W-1:0] ESIK_C = SAYI_W'(ESIK);

  durum_t              r_durum;
  durum_t              w_durum_next;
  logic                w_kabul;
  logic                w_temizle;
  logic                w_bitir;
  logic                w_zaman;
  logic                w_baslat;
  logic                w_basla;
  logic                w_hazir;
  logic [SAYI_W-1:0]   w_sayi;
  logic [SAYI_W-1:0]   w_sayi_sonra;
  logic [YUK_W-1:0]    w_camasir;
  logic [SAYAC_W-1:0]  r_yuk;

  sepet_paketleyici u_paketleyici (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_kabul   (w_kabul),
    .i_temizle (w_temizle),
    .i_parca   (bus.parca),
    .o_camasir (w_camasir),
    .o_sayi    (w_sayi)
  );

  // Launch decision looks at the count including this cycle's garment.
  assign w_sayi_sonra = w_sayi + SAYI_W'(w_kabul);
  assign w_baslat     = (w_sayi_sonra == ESIK_C) ||
                        (bus.hemen && (w_sayi_sonra != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_durum <= TOPLA;
    end else begin
      r_durum <= w_durum_next;
    end
  end

  always_comb begin
    w_durum_next = r_durum;
    unique case (r_durum)
      TOPLA:   if (w_baslat) w_durum_next = BASLAT;
      BASLAT:  w_durum_next = BEKLE;
      BEKLE:   if (w_bitir || w_zaman) w_durum_next = TOPLA;
      default: w_durum_next = TOPLA;
    endcase
  end

  always_comb begin
    w_kabul   = 1'b0;
    w_bitir   = 1'b0;
    w_basla   = 1'b0;
    w_hazir   = 1'b0;
    w_temizle = 1'b0;
    unique case (r_durum)
      TOPLA: begin
        w_hazir = 1'b1;
        w_kabul = bus.parca_gecerli && (bus.parca != PARCA_BOS);
      end
      BASLAT: w_basla = 1'b1;
      BEKLE: begin
        w_bitir   = bus.bitti;
        w_temizle = bus.bitti || w_zaman;
      end
      default: w_hazir = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_yuk <= '0;
    end else if (w_bitir) begin
      r_yuk <= r_yuk + SAYAC_W'(1);
    end
  end

`ifdef ZAMAN_ASIMI_EN
  localparam int WD_W = $clog2(BEKLEME_MAX + 1);

  logic [WD_W-1:0] r_bekleme;
  logic            r_hata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bekleme <= '0;
    end else if (r_durum == BEKLE) begin
      r_bekleme <= r_bekleme + WD_W'(1);
    end else begin
      r_bekleme <= '0;
    end
  end

  // A bitti arriving on the expiry cycle completes normally instead.
  assign w_zaman = (r_durum == BEKLE) && !bus.bitti &&
                   (r_bekleme == WD_W'(BEKLEME_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hata <= 1'b0;
    end else if (w_zaman) begin
      r_hata <= 1'b1;
    end
  end

  assign bus.hata = r_hata;
`else
  assign w_zaman  = 1'b0;
  assign bus.hata = 1'b0;
`endif

  assign bus.camasir    = w_camasir;
  assign bus.basla      = w_basla;
  assign bus.hazir      = w_hazir;
  assign bus.yuk_sayisi = r_yuk;

endmodule
